// File: rtl/uart_io_master_if.sv
// Bus and stream signals of the UART I/O master.
// The master modport is the initiator's view. The slave modport is the view of
// the UART slot together with the stream producer and consumer.
interface uart_io_master_if;
    logic       io_re;
    logic       io_we;
    logic [1:0] io_a;
    logic [7:0] io_wdata;
    logic [7:0] io_rdata;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       cfg_done;

    modport master (
        output io_re, io_we, io_a, io_wdata,
        input  io_rdata,
        input  tx_data, tx_valid,
        output tx_ready,
        output rx_data, rx_valid,
        input  rx_ready,
        output cfg_done
    );

    modport slave (
        input  io_re, io_we, io_a, io_wdata,
        output io_rdata,
        output tx_data, tx_valid,
        input  tx_ready,
        input  rx_data, rx_valid,
        output rx_ready,
        input  cfg_done
    );
endinterface

// File: rtl/uart_io_master.sv
// Hardware initiator for the AVR UART I/O slot.
// After reset it writes UCSRB and then UBRR. From then on it polls UCSRA.
// It feeds UDR from a small TX FIFO and drains UDR into a valid/ready RX stream.
//
//  state    | meaning
//  S_RST    | reset held or first cycle after release, bus idle
//  S_INIT_B | write UCSRB_INIT to addr 2
//  S_INIT_R | write UBRR_INIT to addr 3
//  S_POLL   | read UCSRA (addr 1), decide next action
//  S_RD_UDR | read UDR into rx_data
//  S_WR_UDR | write FIFO head to UDR, pop
module uart_io_master #(
    parameter logic [7:0] UBRR_INIT  = 8'd0,
    parameter logic [7:0] UCSRB_INIT = 8'h00,
    parameter int         FIFO_LOG2  = 2
) (
    input  logic             clk,
    input  logic             rst,
    uart_io_master_if.master bus
);
    localparam logic [FIFO_LOG2:0] C_DEPTH = {1'b1, {FIFO_LOG2{1'b0}}};

    typedef enum logic [2:0] {
        S_RST, S_INIT_B, S_INIT_R, S_POLL, S_RD_UDR, S_WR_UDR
    } state_t;

    state_t               r_state;
    logic                 r_io_re;
    logic                 r_io_we;
    logic [1:0]           r_io_a;
    logic [7:0]           r_io_wdata;
    logic [7:0]           r_rx_data;
    logic                 r_rx_valid;
    logic                 r_cfg_done;

    logic [7:0]           r_mem [C_DEPTH];
    logic [FIFO_LOG2-1:0] r_wr_ptr;
    logic [FIFO_LOG2-1:0] r_rd_ptr;
    logic [FIFO_LOG2:0]   r_count;

    logic                 w_tx_ready;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_fifo_nempty;

    // A full FIFO refuses pushes even when a pop happens in the same cycle.
    assign w_tx_ready    = ~rst & (r_count != C_DEPTH);
    assign w_push        = bus.tx_valid & w_tx_ready;
    assign w_pop         = (r_state == S_WR_UDR);
    assign w_fifo_nempty = (r_count != '0);

    // TX FIFO: circular buffer; the pointers wrap because the depth is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= bus.tx_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Sequencer: the bus outputs are registered from the next state, so they follow the state directly.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_RST;
            r_io_re    <= 1'b0;
            r_io_we    <= 1'b0;
            r_io_a     <= 2'd0;
            r_io_wdata <= 8'h00;
            r_rx_data  <= 8'h00;
            r_rx_valid <= 1'b0;
            r_cfg_done <= 1'b0;
        end else begin
            if (r_rx_valid && bus.rx_ready) begin
                r_rx_valid <= 1'b0;
            end
            case (r_state)
                S_RST: begin
                    r_state    <= S_INIT_B;
                    r_io_we    <= 1'b1;
                    r_io_a     <= 2'd2;
                    r_io_wdata <= UCSRB_INIT;
                end
                S_INIT_B: begin
                    r_state    <= S_INIT_R;
                    r_io_we    <= 1'b1;
                    r_io_a     <= 2'd3;
                    r_io_wdata <= UBRR_INIT;
                end
                S_INIT_R: begin
                    r_state    <= S_POLL;
                    r_cfg_done <= 1'b1;
                    r_io_we    <= 1'b0;
                    r_io_re    <= 1'b1;
                    r_io_a     <= 2'd1;
                    r_io_wdata <= 8'h00;
                end
                S_POLL: begin
                    // RX wins over TX; a new byte is read only when the RX slot is empty.
                    if (bus.io_rdata[7] && !r_rx_valid) begin
                        r_state    <= S_RD_UDR;
                        r_io_re    <= 1'b1;
                        r_io_we    <= 1'b0;
                        r_io_a     <= 2'd0;
                        r_io_wdata <= 8'h00;
                    end else if (bus.io_rdata[5] && w_fifo_nempty) begin
                        r_state    <= S_WR_UDR;
                        r_io_re    <= 1'b0;
                        r_io_we    <= 1'b1;
                        r_io_a     <= 2'd0;
                        r_io_wdata <= r_mem[r_rd_ptr];
                    end else begin
                        r_state    <= S_POLL;
                        r_io_re    <= 1'b1;
                        r_io_we    <= 1'b0;
                        r_io_a     <= 2'd1;
                        r_io_wdata <= 8'h00;
                    end
                end
                S_RD_UDR: begin
                    r_rx_data  <= bus.io_rdata;
                    r_rx_valid <= 1'b1;
                    r_state    <= S_POLL;
                    r_io_re    <= 1'b1;
                    r_io_we    <= 1'b0;
                    r_io_a     <= 2'd1;
                    r_io_wdata <= 8'h00;
                end
                S_WR_UDR: begin
                    r_state    <= S_POLL;
                    r_io_re    <= 1'b1;
                    r_io_we    <= 1'b0;
                    r_io_a     <= 2'd1;
                    r_io_wdata <= 8'h00;
                end
                default: begin
                    r_state    <= S_RST;
                    r_io_re    <= 1'b0;
                    r_io_we    <= 1'b0;
                    r_io_a     <= 2'd0;
                    r_io_wdata <= 8'h00;
                end
            endcase
        end
    end

    assign bus.io_re    = r_io_re;
    assign bus.io_we    = r_io_we;
    assign bus.io_a     = r_io_a;
    assign bus.io_wdata = r_io_wdata;
    assign bus.tx_ready = w_tx_ready;
    assign bus.rx_data  = r_rx_data;
    assign bus.rx_valid = r_rx_valid;
    assign bus.cfg_done = r_cfg_done;
endmodule

// File: tb/tb_uart_io_master.sv
// Directed bench for uart_io_master, with a behavioural UART slot.
module tb_uart_io_master;
    logic clk;
    logic rst;
    logic [7:0] ucsra;
    logic [7:0] udr;
    int n_checks;
    int n_errors;
    logic [11:0] ev_q[$];
    logic accepted;
    int n_rd;

    uart_io_master_if u_if();

    uart_io_master #(
        .UBRR_INIT (8'd12),
        .UCSRB_INIT(8'h18),
        .FIFO_LOG2 (2)
    ) u_dut (
        .clk(clk),
        .rst(rst),
        .bus(u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // UART slot model: the read data is combinational on the address.
    always_comb begin
        u_if.io_rdata = 8'h00;
        if (u_if.io_a == 2'd1) u_if.io_rdata = ucsra;
        else if (u_if.io_a == 2'd0) u_if.io_rdata = udr;
    end

    // Record each bus write and each UDR read, in order.
    always @(posedge clk) begin
        if (u_if.io_we) ev_q.push_back({2'b01, u_if.io_a, u_if.io_wdata});
        if (u_if.io_re && u_if.io_a == 2'd0) ev_q.push_back({2'b10, 2'b00, u_if.io_rdata});
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_bus(input string tag);
        check({tag, "_re"}, u_if.io_re, 1'b0);
        check({tag, "_we"}, u_if.io_we, 1'b0);
        check({tag, "_a"}, u_if.io_a, 2'd0);
        check({tag, "_wd"}, u_if.io_wdata, 8'h00);
    endtask

    task automatic push_byte(input logic [7:0] d);
        u_if.tx_data  = d;
        u_if.tx_valid = 1'b1;
        tick();
        u_if.tx_valid = 1'b0;
    endtask

    task automatic check_init_seq(input string tag);
        tick();
        check({tag, "_b_we"}, u_if.io_we, 1'b1);
        check({tag, "_b_a"}, u_if.io_a, 2'd2);
        check({tag, "_b_d"}, u_if.io_wdata, 8'h18);
        tick();
        check({tag, "_r_we"}, u_if.io_we, 1'b1);
        check({tag, "_r_a"}, u_if.io_a, 2'd3);
        check({tag, "_r_d"}, u_if.io_wdata, 8'h0C);
        tick();
        check({tag, "_cfg"}, u_if.cfg_done, 1'b1);
        check({tag, "_p_re"}, u_if.io_re, 1'b1);
        check({tag, "_p_we"}, u_if.io_we, 1'b0);
        check({tag, "_p_a"}, u_if.io_a, 2'd1);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        ucsra = 8'h00;
        udr = 8'h00;
        u_if.tx_data = 8'h00;
        u_if.tx_valid = 1'b0;
        u_if.rx_ready = 1'b0;

        // Test 1: reset, then the init writes and polling.
        repeat (3) tick();
        check_idle_bus("rst");
        check("rst_txr", u_if.tx_ready, 1'b0);
        check("rst_cfg", u_if.cfg_done, 1'b0);
        check("rst_rxv", u_if.rx_valid, 1'b0);
        check("rst_rxd", u_if.rx_data, 8'h00);
        rst = 1'b0;
        #1;
        check_idle_bus("post_rst");
        check("post_rst_txr", u_if.tx_ready, 1'b1);
        check_init_seq("init");
        repeat (3) tick();
        check("poll_re", u_if.io_re, 1'b1);
        check("poll_a", u_if.io_a, 2'd1);

        // Test 2: a single byte is written to UDR.
        ev_q.delete();
        ucsra = 8'h20;
        u_if.tx_data = 8'h55;
        u_if.tx_valid = 1'b1;
        check("t2_txr", u_if.tx_ready, 1'b1);
        tick();
        u_if.tx_valid = 1'b0;
        check("t2_c1_we", u_if.io_we, 1'b0);
        tick();
        check("t2_we", u_if.io_we, 1'b1);
        check("t2_re", u_if.io_re, 1'b0);
        check("t2_a", u_if.io_a, 2'd0);
        check("t2_d", u_if.io_wdata, 8'h55);
        repeat (6) tick();
        check("t2_nev", ev_q.size(), 1);
        check("t2_txr_end", u_if.tx_ready, 1'b1);
        ucsra = 8'h00;
        tick();

        // Test 3: a received byte is held until rx_ready.
        ev_q.delete();
        ucsra = 8'h80;
        udr = 8'hA3;
        tick();
        check("t3_rd_re", u_if.io_re, 1'b1);
        check("t3_rd_a", u_if.io_a, 2'd0);
        tick();
        check("t3_rxv", u_if.rx_valid, 1'b1);
        check("t3_rxd", u_if.rx_data, 8'hA3);
        ev_q.delete();
        repeat (6) tick();
        check("t3_no_rd", ev_q.size(), 0);
        check("t3_rxd_hold", u_if.rx_data, 8'hA3);
        udr = 8'h3C;
        u_if.rx_ready = 1'b1;
        tick();
        u_if.rx_ready = 1'b0;
        check("t3_rxv_clr", u_if.rx_valid, 1'b0);
        repeat (4) tick();
        n_rd = 0;
        foreach (ev_q[i]) if (ev_q[i][11:10] == 2'b10) n_rd++;
        check("t3_one_rd", n_rd, 1);
        check("t3_rxd2", u_if.rx_data, 8'h3C);
        ucsra = 8'h00;
        u_if.rx_ready = 1'b1;
        tick();
        u_if.rx_ready = 1'b0;
        check("t3_drain", u_if.rx_valid, 1'b0);

        // Test 4: the UDR read precedes the UDR write.
        push_byte(8'h77);
        ev_q.delete();
        ucsra = 8'hA0;
        udr = 8'h5A;
        repeat (6) tick();
        check("t4_nev", ev_q.size(), 2);
        if (ev_q.size() == 2) begin
            check("t4_ev0", ev_q[0], {2'b10, 2'b00, 8'h5A});
            check("t4_ev1", ev_q[1], {2'b01, 2'b00, 8'h77});
        end
        ucsra = 8'h00;
        check("t4_rxd", u_if.rx_data, 8'h5A);
        u_if.rx_ready = 1'b1;
        tick();
        u_if.rx_ready = 1'b0;
        check("t4_drain", u_if.rx_valid, 1'b0);

        // Test 5: fill the FIFO, hold a fifth byte, then drain in push order.
        ev_q.delete();
        push_byte(8'h11);
        push_byte(8'h22);
        push_byte(8'h33);
        check("t5_txr3", u_if.tx_ready, 1'b1);
        push_byte(8'h44);
        check("t5_full", u_if.tx_ready, 1'b0);
        u_if.tx_data = 8'h99;
        u_if.tx_valid = 1'b1;
        tick();
        check("t5_held1", u_if.tx_ready, 1'b0);
        tick();
        check("t5_held2", u_if.tx_ready, 1'b0);
        check("t5_no_wr", ev_q.size(), 0);
        ucsra = 8'h20;
        for (int i = 0; i < 30; i++) begin
            accepted = u_if.tx_valid & u_if.tx_ready;
            tick();
            if (accepted) u_if.tx_valid = 1'b0;
        end
        check("t5_5th_acc", u_if.tx_valid, 1'b0);
        check("t5_nev", ev_q.size(), 5);
        if (ev_q.size() == 5) begin
            check("t5_w0", ev_q[0], {2'b01, 2'b00, 8'h11});
            check("t5_w1", ev_q[1], {2'b01, 2'b00, 8'h22});
            check("t5_w2", ev_q[2], {2'b01, 2'b00, 8'h33});
            check("t5_w3", ev_q[3], {2'b01, 2'b00, 8'h44});
            check("t5_w4", ev_q[4], {2'b01, 2'b00, 8'h99});
        end
        check("t5_txr_end", u_if.tx_ready, 1'b1);

        // Test 6: reset during WR_UDR discards the queue and repeats the init writes.
        ucsra = 8'h00;
        tick();
        push_byte(8'hA1);
        push_byte(8'hA2);
        ucsra = 8'h20;
        tick();
        check("t6_wr_we", u_if.io_we, 1'b1);
        check("t6_wr_d", u_if.io_wdata, 8'hA1);
        rst = 1'b1;
        tick();
        check_idle_bus("t6_rst");
        check("t6_rst_txr", u_if.tx_ready, 1'b0);
        check("t6_rst_cfg", u_if.cfg_done, 1'b0);
        rst = 1'b0;
        #1;
        check_idle_bus("t6_post");
        check("t6_post_txr", u_if.tx_ready, 1'b1);
        check_init_seq("t6_init");
        ev_q.delete();
        repeat (6) tick();
        check("t6_empty", ev_q.size(), 0);
        check("t6_rxv", u_if.rx_valid, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end
endmodule
